input_sequence_checker: RTL
===========================

INPUT_SEQUENCE_CHECKER -- requirements
Module: input_sequence_checker

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 300_000_000, giving the per-press response window in clk cycles (3 s at 100 MHz).
REQ-002 SHALL have parameter HOLD_CYCLES, default 25_000_000, giving the pressed-LED echo time in clk cycles.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  single-cycle request to begin checking.
REQ-006 SHALL have port length  input  3  index of the last bit to check (round number; checks length+1 bits).
REQ-007 SHALL have port pattern  input  8  expected sequence; bit i is the i-th expected press.
REQ-008 SHALL have port right_pressed  input  1  debounced one-cycle pulse meaning "1".
REQ-009 SHALL have port left_pressed  input  1  debounced one-cycle pulse meaning "0".
REQ-010 SHALL have port busy  output  1  high while a check is in progress.
REQ-011 SHALL have port done  output  1  result valid; held until the next accepted start.
REQ-012 SHALL have port correct  output  1  pass flag; meaningful only when done=1.
REQ-013 SHALL have port timeout  output  1  failure was caused by window expiry.
REQ-014 SHALL have port index  output  4  count of correct presses so far (0..8).
REQ-015 SHALL have port led_pressed  output  2  echo of the accepted press: 2'b10 right, 2'b01 left, 2'b00 none.

Function
REQ-016 SHALL implement the states IDLE, WAIT, HOLD, PASS and FAIL.
REQ-017 IDLE: busy=0; on start=1, SHALL latch pattern and length, clear done/correct/timeout/index/timer, and enter WAIT the next cycle.
REQ-018 start SHALL be ignored in every state except IDLE; pattern/length changes after latching SHALL have no effect.
REQ-019 WAIT: timer SHALL increment every cycle; busy=1; led_pressed=2'b00.
REQ-020 WAIT, single pulse whose value equals pattern_q[index]: SHALL set led_pressed, clear the timer, and enter HOLD.
REQ-021 WAIT, single pulse whose value differs from pattern_q[index]: SHALL set led_pressed and enter FAIL; timeout=0.
REQ-022 WAIT, right_pressed and left_pressed high in the same cycle: SHALL be treated as a mismatch and enter FAIL; led_pressed=2'b11.
REQ-023 WAIT, timer reaches TIMEOUT_CYCLES-1 with no press: SHALL set timeout=1 and enter FAIL.
REQ-024 A press arriving in the same cycle the timer expires SHALL take priority over the timeout.
REQ-025 HOLD: SHALL keep led_pressed for exactly HOLD_CYCLES cycles and ignore all presses.
REQ-026 HOLD exit: SHALL increment index and clear led_pressed; if the old index equals length_q, SHALL go to PASS, else to WAIT with the timer at 0.
REQ-027 PASS: SHALL set done=1 and correct=1 for one cycle of residence, then enter IDLE.
REQ-028 FAIL: SHALL set done=1 and correct=0 for one cycle of residence, then enter IDLE; led_pressed SHALL clear on IDLE entry.
REQ-029 done, correct, timeout and index SHALL hold in IDLE until the next accepted start.
REQ-030 index SHALL never exceed length_q+1; the timer SHALL be at least 32 bits and never wrap.

Reset
REQ-031 While reset=0, SHALL force state IDLE and busy=0, done=0, correct=0, timeout=0, index=0, led_pressed=0, and timer=0, asynchronously.
REQ-032 Reset asserted mid-check SHALL abandon the check with no done pulse; the first start after release SHALL begin a fresh check.

Verification (TIMEOUT_CYCLES=20, HOLD_CYCLES=4)
REQ-033 Full pass: start, length=2, pattern=8'b0000_0101; presses R,L,R, each 3 cycles after WAIT entry -> index 1,2,3; done=1, correct=1, timeout=0, busy=0.
REQ-034 Wrong bit: length=3, pattern=8'b0000_0110; press R at index 0 -> led_pressed=2'b10, done=1, correct=0, index=0.
REQ-035 Timeout: length=0, no press -> FAIL entered exactly 20 cycles after WAIT entry; timeout=1, correct=0.
REQ-036 Edge cases: a correct press on the expiry cycle -> HOLD, not FAIL; both buttons pressed together -> FAIL with led_pressed=2'b11; presses during HOLD -> no effect on index.
REQ-037 Start while busy is ignored (latched pattern unchanged); reset pulsed at index=2 -> all outputs 0; a new start then checks from index 0.

Source files
------------

// File: rtl/input_sequence_checker.sv
// Checks a sequence of debounced left/right presses against a latched bit pattern,
// with a per-press response window and a pressed-LED echo phase between presses.
module input_sequence_checker #(
  parameter int unsigned TIMEOUT_CYCLES = 300_000_000,
  parameter int unsigned HOLD_CYCLES    = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] length,
  input  logic [7:0] pattern,
  input  logic       right_pressed,
  input  logic       left_pressed,
  output logic       busy,
  output logic       done,
  output logic       correct,
  output logic       timeout,
  output logic [3:0] index,
  output logic [1:0] led_pressed
);

  localparam int unsigned TW = 32;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LAST  = TW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    HOLD = 3'd2,
    PASS = 3'd3,
    FAIL = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [TW-1:0] hold_cnt, hold_cnt_n;
  logic [7:0]    pattern_q, pattern_n;
  logic [2:0]    length_q, length_n;
  logic          busy_n, done_n, correct_n, timeout_n;
  logic [3:0]    index_n;
  logic [1:0]    led_n;
  logic          expected_bit;

  assign expected_bit = pattern_q[index[2:0]];

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      timer       <= '0;
      hold_cnt    <= '0;
      pattern_q   <= '0;
      length_q    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      correct     <= 1'b0;
      timeout     <= 1'b0;
      index       <= '0;
      led_pressed <= '0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      hold_cnt    <= hold_cnt_n;
      pattern_q   <= pattern_n;
      length_q    <= length_n;
      busy        <= busy_n;
      done        <= done_n;
      correct     <= correct_n;
      timeout     <= timeout_n;
      index       <= index_n;
      led_pressed <= led_n;
    end
  end

  // Next-state and next-output logic; outputs track the state they will sit beside
  always_comb begin
    state_n    = state;
    timer_n    = timer;
    hold_cnt_n = hold_cnt;
    pattern_n  = pattern_q;
    length_n   = length_q;
    busy_n     = busy;
    done_n     = done;
    correct_n  = correct;
    timeout_n  = timeout;
    index_n    = index;
    led_n      = led_pressed;

    case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (start) begin
          pattern_n = pattern;
          length_n  = length;
          done_n    = 1'b0;
          correct_n = 1'b0;
          timeout_n = 1'b0;
          index_n   = '0;
          timer_n   = '0;
          led_n     = 2'b00;
          busy_n    = 1'b1;
          state_n   = WAIT;
        end
      end

      WAIT: begin
        timer_n = timer + TW'(1);
        // A press in the expiry cycle wins over the timeout
        if (right_pressed || left_pressed) begin
          led_n = {right_pressed, left_pressed};
          if (!(right_pressed && left_pressed) && (right_pressed == expected_bit)) begin
            timer_n    = '0;
            hold_cnt_n = '0;
            state_n    = HOLD;
          end else begin
            busy_n    = 1'b0;
            done_n    = 1'b1;
            correct_n = 1'b0;
            timeout_n = 1'b0;
            state_n   = FAIL;
          end
        end else if (timer >= TIMER_LAST) begin
          busy_n    = 1'b0;
          done_n    = 1'b1;
          correct_n = 1'b0;
          timeout_n = 1'b1;
          state_n   = FAIL;
        end
      end

      HOLD: begin
        if (hold_cnt >= HOLD_LAST) begin
          index_n = index + 4'd1;
          led_n   = 2'b00;
          if (index == {1'b0, length_q}) begin
            busy_n    = 1'b0;
            done_n    = 1'b1;
            correct_n = 1'b1;
            state_n   = PASS;
          end else begin
            timer_n = '0;
            state_n = WAIT;
          end
        end else begin
          hold_cnt_n = hold_cnt + TW'(1);
        end
      end

      PASS, FAIL: begin
        led_n   = 2'b00;
        busy_n  = 1'b0;
        state_n = IDLE;
      end

      default: begin
        busy_n  = 1'b0;
        led_n   = 2'b00;
        state_n = IDLE;
      end
    endcase
  end

endmodule
